// File: rtl/window_line_buffer.sv
// Raster-to-window producer: turns a one-pixel-per-cycle raster stream into a
// winW x winH neighbourhood using winH-1 line buffers and a column shift array.
module window_line_buffer #(
    parameter int winW  = 5,
    parameter int winH  = winW,
    parameter int dataW = 8,
    parameter int imgW  = 640,
    parameter int imgH  = 480,
    parameter int CW    = $clog2(imgW),
    parameter int RW    = $clog2(imgH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [dataW-1:0]             in_data,
    output logic [winW*winH*dataW-1:0]   window,
    output logic                         win_valid,
    output logic [CW-1:0]                win_x,
    output logic [RW-1:0]                win_y,
    output logic                         frame_done,
    output logic                         sync_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_reg;
    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_reg;
    logic              win_valid_reg;
    logic [CW-1:0]     win_x_reg;
    logic [RW-1:0]     win_y_reg;
    logic              frame_done_reg;
    logic              sync_err_reg;
    logic [dataW-1:0]  win_reg [winH][winW];

    logic              proc;
    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic              last_col;
    logic              last_row;
    logic              qualify;
    logic              sof_err;
    logic [dataW-1:0]  lb_rd   [winH-1];
    logic [dataW-1:0]  new_col [winH];

    // A start-of-frame pixel is always handled as (0,0), whatever the counters say.
    assign proc     = en && in_valid && (in_sof || state_reg == ACTIVE);
    assign cur_col  = in_sof ? '0 : col_reg;
    assign cur_row  = in_sof ? '0 : row_reg;
    assign last_col = (cur_col == CW'(imgW - 1));
    assign last_row = (cur_row == RW'(imgH - 1));
    assign qualify  = (cur_row >= RW'(winH - 1)) && (cur_col >= CW'(winW - 1));
    assign sof_err  = in_sof && (state_reg == ACTIVE) && ((col_reg != '0) || (row_reg != '0));

    // Buffer k holds row r-1-k; each one is read at column c before being
    // overwritten, so the cascade ages every stored row by one per pass.
    generate
        for (genvar gi = 0; gi < winH - 1; gi++) begin : g_line
            logic [dataW-1:0] mem [imgW];
            assign lb_rd[gi] = mem[cur_col];
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (proc) mem[cur_col] <= in_data;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (proc) mem[cur_col] <= lb_rd[gi-1];
                end
            end
        end

        for (genvar gi = 0; gi < winH; gi++) begin : g_col
            if (gi == winH - 1) begin : g_newest
                assign new_col[gi] = in_data;
            end else begin : g_older
                assign new_col[gi] = lb_rd[winH-2-gi];
            end
        end

        for (genvar gi = 0; gi < winH; gi++) begin : g_pack_y
            for (genvar gj = 0; gj < winW; gj++) begin : g_pack_x
                assign window[(gi*winW+gj)*dataW +: dataW] = win_reg[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            win_x_reg      <= '0;
            win_y_reg      <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else if (en) begin
            win_valid_reg  <= proc && qualify;
            frame_done_reg <= proc && last_row && last_col;
            sync_err_reg   <= proc && sof_err;
            if (proc) begin
                if (qualify) begin
                    win_x_reg <= cur_col - CW'((winW - 1) / 2);
                    win_y_reg <= cur_row - RW'((winH - 1) / 2);
                end
                if (last_col) begin
                    col_reg <= '0;
                    if (last_row) begin
                        row_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        row_reg   <= cur_row + 1'b1;
                        state_reg <= ACTIVE;
                    end
                end else begin
                    col_reg   <= cur_col + 1'b1;
                    row_reg   <= cur_row;
                    state_reg <= ACTIVE;
                end
            end
        end
    end

    // Newest column enters at gx=winW-1; the oldest falls off gx=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int gy = 0; gy < winH; gy++) begin
                for (int gx = 0; gx < winW; gx++) begin
                    win_reg[gy][gx] <= '0;
                end
            end
        end else if (proc) begin
            for (int gy = 0; gy < winH; gy++) begin
                for (int gx = 0; gx < winW - 1; gx++) begin
                    win_reg[gy][gx] <= win_reg[gy][gx+1];
                end
                win_reg[gy][winW-1] <= new_col[gy];
            end
        end
    end

    assign win_valid  = win_valid_reg;
    assign win_x      = win_x_reg;
    assign win_y      = win_y_reg;
    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_window_line_buffer.sv
// Self-checking bench for window_line_buffer: frame-image model feeding a
// scoreboard queue, a small vector table for IDLE behaviour, and corner sequences.
module tb_window_line_buffer;

    localparam int W  = 3;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int CW = 3;
    localparam int RW = 3;
    localparam int NB = W * H * DW;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic [NB-1:0] window;
    logic          win_valid;
    logic [CW-1:0] win_x;
    logic [RW-1:0] win_y;
    logic          frame_done;
    logic          sync_err;

    window_line_buffer #(
        .winW(W), .winH(H), .dataW(DW), .imgW(IW), .imgH(IH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .window(window), .win_valid(win_valid), .win_x(win_x),
        .win_y(win_y), .frame_done(frame_done), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          fd;
        logic          se;
        logic [CW-1:0] x;
        logic [RW-1:0] y;
        logic [NB-1:0] win;
    } exp_t;

    typedef struct {
        bit          en;
        bit          valid;
        bit          sof;
        logic [7:0]  data;
        bit          exp_valid;
        bit          exp_fd;
        bit          exp_se;
    } vec_t;

    exp_t sb_q[$];
    exp_t m_exp;
    bit   m_active;
    int   m_row;
    int   m_col;
    logic [7:0] img [IH][IW];

    int tests;
    int failed;
    int n_acc, n_valid, n_fd, n_se, first_acc;
    bit seen_valid;
    logic [CW-1:0] first_x;
    logic [RW-1:0] first_y;
    logic [NB-1:0] first_win;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_row     = 0;
        m_col     = 0;
        m_exp.valid = 1'b0;
        m_exp.fd    = 1'b0;
        m_exp.se    = 1'b0;
        m_exp.x     = '0;
        m_exp.y     = '0;
        m_exp.win   = '0;
    endtask

    task automatic clear_stats();
        n_acc = 0; n_valid = 0; n_fd = 0; n_se = 0; first_acc = 0;
        seen_valid = 1'b0;
        first_x = '0; first_y = '0; first_win = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_window"},    128'(window), 128'(0));
        check({tag, "_win_valid"}, 128'(win_valid), 128'(0));
        check({tag, "_win_x"},     128'(win_x), 128'(0));
        check({tag, "_win_y"},     128'(win_y), 128'(0));
        check({tag, "_frame_done"},128'(frame_done), 128'(0));
        check({tag, "_sync_err"},  128'(sync_err), 128'(0));
    endtask

    // One clock: update the model, push its expectation, drive, then compare.
    task automatic step(input bit e, input bit v, input bit s, input logic [7:0] d);
        exp_t ex;
        int r, c;
        if (e) begin
            m_exp.valid = 1'b0;
            m_exp.fd    = 1'b0;
            m_exp.se    = 1'b0;
            if (v && (m_active || s)) begin
                r = s ? 0 : m_row;
                c = s ? 0 : m_col;
                m_exp.se = s && m_active && (m_row != 0 || m_col != 0);
                img[r][c] = d;
                n_acc++;
                if (r >= H - 1 && c >= W - 1) begin
                    m_exp.valid = 1'b1;
                    m_exp.x = CW'(c - (W - 1) / 2);
                    m_exp.y = RW'(r - (H - 1) / 2);
                    for (int gy = 0; gy < H; gy++)
                        for (int gx = 0; gx < W; gx++)
                            m_exp.win[(gy*W+gx)*DW +: DW] = img[r-H+1+gy][c-W+1+gx];
                end
                if (r == IH - 1 && c == IW - 1) begin
                    m_exp.fd = 1'b1;
                    m_active = 1'b0;
                    m_row = 0;
                    m_col = 0;
                end else begin
                    m_active = 1'b1;
                    if (c == IW - 1) begin
                        m_col = 0;
                        m_row = r + 1;
                    end else begin
                        m_col = c + 1;
                        m_row = r;
                    end
                end
            end
        end
        sb_q.push_back(m_exp);
        en = e; in_valid = v; in_sof = s; in_data = d;
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        check("win_valid",  128'(win_valid),  128'(ex.valid));
        check("frame_done", 128'(frame_done), 128'(ex.fd));
        check("sync_err",   128'(sync_err),   128'(ex.se));
        if (ex.valid) begin
            check("win_x",  128'(win_x),  128'(ex.x));
            check("win_y",  128'(win_y),  128'(ex.y));
            check("window", 128'(window), 128'(ex.win));
        end
        if (e) begin
            if (win_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    first_acc = n_acc;
                    first_x = win_x;
                    first_y = win_y;
                    first_win = window;
                end
                n_valid++;
            end
            if (frame_done) n_fd++;
            if (sync_err) n_se++;
        end
    endtask

    // Raster pixels start..start+n-1 of a frame; index 0 carries in_sof.
    task automatic send_pixels(input int start, input int n, input logic [7:0] xorv, input bit rnd);
        int r, c;
        for (int i = start; i < start + n; i++) begin
            r = i / IW;
            c = i % IW;
            if (rnd) begin
                while ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 3) == 0) begin
                        for (int k = 0; k < 3; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h99);
                    end else begin
                        step(1'b1, 1'b0, 1'b0, 8'h77);
                    end
                end
            end
            step(1'b1, 1'b1, (i == 0), 8'(r * 16 + c) ^ xorv);
        end
    endtask

    task automatic check_first_frame(input string tag);
        check({tag, "_first_acc"}, 128'(first_acc), 128'(19));
        check({tag, "_first_x"},   128'(first_x), 128'(1));
        check({tag, "_first_y"},   128'(first_y), 128'(1));
        check({tag, "_el00"},      128'(first_win[0 +: 8]), 128'(8'h00));
        check({tag, "_el11"},      128'(first_win[32 +: 8]), 128'(8'h11));
        check({tag, "_el22"},      128'(first_win[64 +: 8]), 128'(8'h22));
        check({tag, "_n_valid"},   128'(n_valid), 128'(24));
        check({tag, "_n_done"},    128'(n_fd), 128'(1));
        check({tag, "_n_syncerr"}, 128'(n_se), 128'(0));
    endtask

    vec_t tbl [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        failed = 0;
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // IDLE: pixels without in_sof, and in_sof without acceptance, change nothing.
        tbl[0] = '{en:1, valid:1, sof:0, data:8'h99, exp_valid:0, exp_fd:0, exp_se:0};
        tbl[1] = '{en:1, valid:1, sof:0, data:8'h99, exp_valid:0, exp_fd:0, exp_se:0};
        tbl[2] = '{en:0, valid:1, sof:1, data:8'h99, exp_valid:0, exp_fd:0, exp_se:0};
        tbl[3] = '{en:1, valid:0, sof:1, data:8'h99, exp_valid:0, exp_fd:0, exp_se:0};
        tbl[4] = '{en:1, valid:1, sof:0, data:8'h99, exp_valid:0, exp_fd:0, exp_se:0};
        tbl[5] = '{en:1, valid:0, sof:0, data:8'h99, exp_valid:0, exp_fd:0, exp_se:0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].en, tbl[i].valid, tbl[i].sof, tbl[i].data);
            check("tbl_win_valid",  128'(win_valid),  128'(tbl[i].exp_valid));
            check("tbl_frame_done", 128'(frame_done), 128'(tbl[i].exp_fd));
            check("tbl_sync_err",   128'(sync_err),   128'(tbl[i].exp_se));
        end

        // Continuous full frame.
        clear_stats();
        send_pixels(0, IW * IH, 8'h00, 1'b0);
        check_first_frame("cont");
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Gappy valid with en-low bursts.
        clear_stats();
        send_pixels(0, IW * IH, 8'h00, 1'b1);
        check_first_frame("rand");
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // in_sof arriving at (3,4).
        clear_stats();
        send_pixels(0, 3 * IW + 4, 8'h00, 1'b0);
        clear_stats();
        send_pixels(0, IW * IH, 8'h00, 1'b0);
        check("sync_n_syncerr", 128'(n_se), 128'(1));
        check("sync_first_acc", 128'(first_acc), 128'(19));
        check("sync_first_x",   128'(first_x), 128'(1));
        check("sync_first_y",   128'(first_y), 128'(1));
        check("sync_n_valid",   128'(n_valid), 128'(24));

        // Asynchronous reset pulse with the next pixel at (4,5).
        clear_stats();
        send_pixels(0, 4 * IW + 5, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        #8 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'h55);
        clear_stats();
        send_pixels(0, IW * IH, 8'h00, 1'b0);
        check_first_frame("post_rst");

        // Back-to-back frames; frame 2 carries distinct data.
        clear_stats();
        send_pixels(0, IW * IH, 8'h00, 1'b0);
        check("b2b1_n_done",    128'(n_fd), 128'(1));
        check("b2b1_n_syncerr", 128'(n_se), 128'(0));
        clear_stats();
        send_pixels(0, IW * IH, 8'h80, 1'b0);
        check("b2b2_n_done",    128'(n_fd), 128'(1));
        check("b2b2_n_syncerr", 128'(n_se), 128'(0));
        check("b2b2_n_valid",   128'(n_valid), 128'(24));
        check("b2b2_el00",      128'(first_win[0 +: 8]), 128'(8'h80));
        check("b2b2_el11",      128'(first_win[32 +: 8]), 128'(8'h91));
        step(1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
